// File: rtl/bdm_host_cmd_parser.sv
// Host command front end for the bdm core: buffers UART bytes, decodes
// opcode/operand pairs into one-cycle bdm strobes and returns result bytes.
module bdm_host_cmd_parser #(
  parameter int RX_FIFO_DEPTH = 4,
  parameter int RESP_TIMEOUT  = 65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_busy,
  output logic       do_read,
  output logic       do_write,
  output logic       do_start_mcu,
  output logic       do_stop_mcu,
  output logic       do_delay,
  output logic       do_echo_test,
  output logic [7:0] bdm_data_in,
  input  logic       bdm_ready,
  input  logic       bdm_valid,
  input  logic [7:0] bdm_data_out,
  output logic       rx_overflow
);

  localparam int PTR_W = (RX_FIFO_DEPTH > 1) ? $clog2(RX_FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(RESP_TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_ARG, S_ISSUE, S_WAIT, S_RESP} state_t;
  typedef enum logic [2:0] {CMD_START, CMD_STOP, CMD_READ, CMD_WRITE, CMD_DELAY, CMD_ECHO} cmd_t;
  typedef struct packed {
    logic known;
    logic has_arg;
    cmd_t cmd;
  } op_t;

  function automatic op_t decode_op(input logic [7:0] b);
    op_t o;
    o.known   = 1'b1;
    o.has_arg = 1'b0;
    o.cmd     = CMD_START;
    case (b)
      8'h73: o.cmd = CMD_START;
      8'h78: o.cmd = CMD_STOP;
      8'h72: o.cmd = CMD_READ;
      8'h77: begin o.cmd = CMD_WRITE; o.has_arg = 1'b1; end
      8'h64: begin o.cmd = CMD_DELAY; o.has_arg = 1'b1; end
      8'h65: begin o.cmd = CMD_ECHO;  o.has_arg = 1'b1; end
      default: o.known = 1'b0;
    endcase
    return o;
  endfunction

  state_t           state, state_nxt;
  cmd_t             cmd;
  logic [7:0]       mem [RX_FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic [TMR_W-1:0] timer;
  logic [7:0]       resp_byte;
  logic             fifo_empty, fifo_full, push, pop;
  logic [7:0]       head;
  op_t              head_op;
  logic             any_do, load_op, load_arg, fire, latch_resp, tx_fire;
  logic             timer_clr, timer_inc;
  logic [7:0]       resp_val;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(RX_FIFO_DEPTH));
  assign head       = mem[rd_ptr];
  assign head_op    = decode_op(head);
  // A pop in the same cycle frees the slot, so a byte arriving on a full FIFO is still kept.
  assign push       = rx_valid && (!fifo_full || pop);
  assign any_do     = do_read | do_write | do_start_mcu | do_stop_mcu | do_delay | do_echo_test;

  // Byte storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_data;
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      rx_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (rx_valid && !push) rx_overflow <= 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and per-state control pulses.
  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    load_op    = 1'b0;
    load_arg   = 1'b0;
    fire       = 1'b0;
    latch_resp = 1'b0;
    resp_val   = 8'h00;
    tx_fire    = 1'b0;
    timer_clr  = 1'b0;
    timer_inc  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (!head_op.known) begin
            latch_resp = 1'b1;
            resp_val   = 8'h3F;
            state_nxt  = S_RESP;
          end else begin
            load_op   = 1'b1;
            state_nxt = head_op.has_arg ? S_ARG : S_ISSUE;
          end
        end
      end
      S_ARG: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          load_arg  = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bdm_ready && !any_do) begin
          fire      = 1'b1;
          timer_clr = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // The strobe cycle itself (any_do high) never completes the command.
        if (cmd == CMD_READ || cmd == CMD_ECHO) begin
          if (bdm_valid && !any_do) begin
            latch_resp = 1'b1;
            resp_val   = bdm_data_out;
            state_nxt  = S_RESP;
          end else if (timer == TMR_W'(RESP_TIMEOUT)) begin
            latch_resp = 1'b1;
            resp_val   = 8'hEE;
            state_nxt  = S_RESP;
          end else begin
            timer_inc = 1'b1;
          end
        end else if (bdm_ready && !any_do) begin
          state_nxt = S_IDLE;
        end
      end
      S_RESP: begin
        if (!tx_busy) begin
          tx_fire   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Registered command/operand, response byte, timer and output strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd          <= CMD_START;
      bdm_data_in  <= 8'h00;
      resp_byte    <= 8'h00;
      timer        <= '0;
      do_read      <= 1'b0;
      do_write     <= 1'b0;
      do_start_mcu <= 1'b0;
      do_stop_mcu  <= 1'b0;
      do_delay     <= 1'b0;
      do_echo_test <= 1'b0;
      tx_valid     <= 1'b0;
      tx_data      <= 8'h00;
    end else begin
      if (load_op)    cmd         <= head_op.cmd;
      if (load_arg)   bdm_data_in <= head;
      if (latch_resp) resp_byte   <= resp_val;
      if (timer_clr)      timer <= '0;
      else if (timer_inc) timer <= timer + 1'b1;
      do_start_mcu <= fire && (cmd == CMD_START);
      do_stop_mcu  <= fire && (cmd == CMD_STOP);
      do_read      <= fire && (cmd == CMD_READ);
      do_write     <= fire && (cmd == CMD_WRITE);
      do_delay     <= fire && (cmd == CMD_DELAY);
      do_echo_test <= fire && (cmd == CMD_ECHO);
      tx_valid     <= tx_fire;
      if (tx_fire) tx_data <= resp_byte;
    end
  end

endmodule

// File: tb/tb_bdm_host_cmd_parser.sv
// Directed bench for bdm_host_cmd_parser with a small behavioural bdm model.
module tb_bdm_host_cmd_parser;

  localparam int DEPTH = 4;
  localparam int TO    = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_busy = 1'b0;
  logic       do_read, do_write, do_start_mcu, do_stop_mcu, do_delay, do_echo_test;
  logic [7:0] bdm_data_in;
  logic       bdm_ready;
  logic       bdm_valid = 1'b0;
  logic [7:0] bdm_data_out = 8'h00;
  logic       rx_overflow;

  int vectors = 0;
  int errors  = 0;

  bdm_host_cmd_parser #(.RX_FIFO_DEPTH(DEPTH), .RESP_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_busy(tx_busy),
    .do_read(do_read), .do_write(do_write), .do_start_mcu(do_start_mcu),
    .do_stop_mcu(do_stop_mcu), .do_delay(do_delay), .do_echo_test(do_echo_test),
    .bdm_data_in(bdm_data_in), .bdm_ready(bdm_ready), .bdm_valid(bdm_valid),
    .bdm_data_out(bdm_data_out), .rx_overflow(rx_overflow)
  );

  always #5 clk = ~clk;

  logic any_do;
  assign any_do = do_read | do_write | do_start_mcu | do_stop_mcu | do_delay | do_echo_test;

  // bdm model: busy for a few cycles after each command, echo returns its operand.
  logic       force_busy = 1'b0;
  int         busy_cnt = 0;
  int         valid_cnt = 0;
  logic [7:0] valid_data = 8'h00;
  assign bdm_ready = !force_busy && (busy_cnt == 0) && !any_do;

  always @(posedge clk) begin
    bdm_valid <= 1'b0;
    if (!rst_n) begin
      busy_cnt  <= 0;
      valid_cnt <= 0;
    end else begin
      if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
      if (valid_cnt > 0) begin
        valid_cnt <= valid_cnt - 1;
        if (valid_cnt == 1) begin
          bdm_valid    <= 1'b1;
          bdm_data_out <= valid_data;
        end
      end
      if (do_echo_test) begin
        busy_cnt   <= 3;
        valid_cnt  <= 3;
        valid_data <= bdm_data_in;
      end
      if (do_read) busy_cnt <= 3;
      if (do_write | do_start_mcu | do_stop_mcu) busy_cnt <= 2;
      if (do_delay) busy_cnt <= 5;
    end
  end

  // Event monitor: strobe/tx counts, operand at strobe, protocol violations.
  int n_start = 0, n_stop = 0, n_read = 0, n_write = 0, n_delay = 0, n_echo = 0;
  int n_tx = 0, viol = 0, cyc = 0, last_do_cyc = 0, last_tx_cyc = 0;
  logic [7:0] last_tx = 8'h00, last_arg = 8'h00;
  logic prev_any = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    prev_any <= any_do;
    if (do_start_mcu) n_start <= n_start + 1;
    if (do_stop_mcu)  n_stop  <= n_stop + 1;
    if (do_read)      n_read  <= n_read + 1;
    if (do_write)     n_write <= n_write + 1;
    if (do_delay)     n_delay <= n_delay + 1;
    if (do_echo_test) n_echo  <= n_echo + 1;
    if (any_do) begin
      last_do_cyc <= cyc;
      last_arg    <= bdm_data_in;
    end
    if ((32'(do_start_mcu) + 32'(do_stop_mcu) + 32'(do_read) + 32'(do_write) +
         32'(do_delay) + 32'(do_echo_test)) > 1 || (any_do && prev_any) || (tx_valid && tx_busy))
      viol <= viol + 1;
    if (tx_valid) begin
      n_tx        <= n_tx + 1;
      last_tx     <= tx_data;
      last_tx_cyc <= cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int base, input int budget, output logic ok);
    int k;
    k = 0;
    while (n_tx == base && k < budget) begin
      tick(1);
      k++;
    end
    ok = (n_tx != base);
  endtask

  function automatic logic [23:0] out_vec();
    return {tx_valid, tx_data, do_read, do_write, do_start_mcu, do_stop_mcu,
            do_delay, do_echo_test, bdm_data_in, rx_overflow};
  endfunction

  task automatic test_reset();
    tick(2);
    vectors++;
    if (out_vec() !== 24'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 000000", out_vec());
    end
    rst_n = 1'b1;
    tick(3);
    vectors++;
    if (out_vec() !== 24'h0) begin
      errors++;
      $display("FAIL idle_after_reset: got %h want 000000", out_vec());
    end
  endtask

  task automatic test_echo();
    int e0, t0;
    logic ok;
    e0 = n_echo; t0 = n_tx;
    send_byte(8'h65);
    send_byte(8'h5A);
    wait_tx(t0, 50, ok);
    vectors++;
    if (ok !== 1'b1) begin errors++; $display("FAIL echo_tx_timeout: got none want 1 byte"); end
    tick(20);
    vectors++;
    if (n_echo - e0 !== 1) begin errors++; $display("FAIL echo_pulses: got %0d want 1", n_echo - e0); end
    vectors++;
    if (last_arg !== 8'h5A) begin errors++; $display("FAIL echo_arg: got %h want 5a", last_arg); end
    vectors++;
    if (last_tx !== 8'h5A || n_tx - t0 !== 1) begin
      errors++; $display("FAIL echo_tx: got %h x%0d want 5a x1", last_tx, n_tx - t0);
    end
    vectors++;
    if (last_tx_cyc - last_do_cyc < 3) begin
      errors++; $display("FAIL echo_latency: got %0d want >=3", last_tx_cyc - last_do_cyc);
    end
  endtask

  task automatic test_ready_stall();
    int s0;
    s0 = n_start;
    force_busy = 1'b1;
    send_byte(8'h73);
    tick(20);
    vectors++;
    if (n_start !== s0 || do_start_mcu !== 1'b0) begin
      errors++; $display("FAIL start_while_busy: got %0d pulses want 0", n_start - s0);
    end
    force_busy = 1'b0;
    tick(1);
    vectors++;
    if (do_start_mcu !== 1'b1) begin errors++; $display("FAIL start_after_ready: got %b want 1", do_start_mcu); end
    tick(1);
    vectors++;
    if (do_start_mcu !== 1'b0) begin errors++; $display("FAIL start_width: got %b want 0", do_start_mcu); end
    tick(10);
    vectors++;
    if (n_start - s0 !== 1) begin errors++; $display("FAIL start_pulses: got %0d want 1", n_start - s0); end
  endtask

  task automatic test_read_timeout();
    int r0, t0, x0;
    logic ok;
    r0 = n_read; t0 = n_tx;
    send_byte(8'h72);
    wait_tx(t0, TO + 50, ok);
    vectors++;
    if (ok !== 1'b1 || last_tx !== 8'hEE) begin
      errors++; $display("FAIL read_timeout_byte: got %h ok=%b want ee", last_tx, ok);
    end
    vectors++;
    if (n_read - r0 !== 1 || last_tx_cyc - last_do_cyc < TO) begin
      errors++; $display("FAIL read_timeout_len: got %0d cycles reads %0d want >=%0d reads 1",
                         last_tx_cyc - last_do_cyc, n_read - r0, TO);
    end
    x0 = n_stop; t0 = n_tx;
    send_byte(8'h78);
    tick(20);
    vectors++;
    if (n_stop - x0 !== 1 || n_tx !== t0) begin
      errors++; $display("FAIL stop_after_timeout: got stops %0d tx %0d want 1 0", n_stop - x0, n_tx - t0);
    end
  endtask

  task automatic test_unknown_and_write();
    int d0, w0, t0;
    logic ok;
    d0 = n_start + n_stop + n_read + n_write + n_delay + n_echo;
    t0 = n_tx;
    tx_busy = 1'b1;
    send_byte(8'h41);
    tick(10);
    vectors++;
    if (n_tx !== t0) begin errors++; $display("FAIL tx_while_busy: got %0d bytes want 0", n_tx - t0); end
    tx_busy = 1'b0;
    wait_tx(t0, 20, ok);
    tick(5);
    vectors++;
    if (ok !== 1'b1 || last_tx !== 8'h3F) begin
      errors++; $display("FAIL unknown_resp: got %h ok=%b want 3f", last_tx, ok);
    end
    vectors++;
    if (n_start + n_stop + n_read + n_write + n_delay + n_echo !== d0) begin
      errors++; $display("FAIL unknown_strobe: got %0d want 0",
                         n_start + n_stop + n_read + n_write + n_delay + n_echo - d0);
    end
    w0 = n_write; t0 = n_tx;
    send_byte(8'h77);
    send_byte(8'h41);
    tick(20);
    vectors++;
    if (n_write - w0 !== 1 || last_arg !== 8'h41) begin
      errors++; $display("FAIL write_cmd: got %0d pulses arg %h want 1 41", n_write - w0, last_arg);
    end
    vectors++;
    if (n_tx !== t0) begin errors++; $display("FAIL write_no_tx: got %0d bytes want 0", n_tx - t0); end
  endtask

  task automatic test_back_to_back();
    int s0, x0, w0, e0, t0;
    logic [7:0] seq [6];
    seq = '{8'h77, 8'h11, 8'h65, 8'h22, 8'h73, 8'h78};
    s0 = n_start; x0 = n_stop; w0 = n_write; e0 = n_echo; t0 = n_tx;
    force_busy = 1'b1;
    send_byte(8'h73);
    tick(3);
    for (int i = 0; i < 6; i++) begin
      rx_data  = seq[i];
      rx_valid = 1'b1;
      tick(1);
    end
    rx_valid = 1'b0;
    vectors++;
    if (rx_overflow !== 1'b1) begin errors++; $display("FAIL overflow_flag: got %b want 1", rx_overflow); end
    force_busy = 1'b0;
    tick(80);
    vectors++;
    if (n_start - s0 !== 1 || n_stop !== x0) begin
      errors++; $display("FAIL overflow_drop: got start %0d stop %0d want 1 0", n_start - s0, n_stop - x0);
    end
    vectors++;
    if (n_write - w0 !== 1 || n_echo - e0 !== 1 || n_tx - t0 !== 1 || last_tx !== 8'h22) begin
      errors++; $display("FAIL overflow_kept: got w%0d e%0d tx%0d %h want w1 e1 tx1 22",
                         n_write - w0, n_echo - e0, n_tx - t0, last_tx);
    end
    vectors++;
    if (viol !== 0) begin errors++; $display("FAIL strobe_protocol: got %0d violations want 0", viol); end
  endtask

  task automatic test_reset_midcmd();
    int s0, w0, d0, t0, k;
    d0 = n_delay;
    send_byte(8'h64);
    send_byte(8'hFF);
    k = 0;
    while (n_delay == d0 && k < 20) begin tick(1); k++; end
    vectors++;
    if (n_delay == d0) begin errors++; $display("FAIL delay_strobe: got none want 1"); end
    force_busy = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    vectors++;
    if (out_vec() !== 24'h0) begin errors++; $display("FAIL async_reset: got %h want 000000", out_vec()); end
    tick(2);
    #3 rst_n = 1'b1;
    force_busy = 1'b0;
    tick(2);
    send_byte(8'h77);
    tick(3);
    #3 rst_n = 1'b0;
    tick(2);
    #3 rst_n = 1'b1;
    tick(2);
    s0 = n_start; w0 = n_write; d0 = n_delay; t0 = n_tx;
    send_byte(8'h73);
    tick(20);
    vectors++;
    if (n_start - s0 !== 1 || n_write !== w0 || n_delay !== d0 || n_tx !== t0) begin
      errors++; $display("FAIL after_reset: got s%0d w%0d d%0d tx%0d want s1 w0 d0 tx0",
                         n_start - s0, n_write - w0, n_delay - d0, n_tx - t0);
    end
    vectors++;
    if (rx_overflow !== 1'b0) begin errors++; $display("FAIL overflow_clear: got %b want 0", rx_overflow); end
  endtask

  initial begin
    test_reset();
    test_echo();
    test_ready_stall();
    test_read_timeout();
    test_unknown_and_write();
    test_back_to_back();
    test_reset_midcmd();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
